// File: rtl/irq_ctl_pkg.sv
// Shared constants and ID helpers for the external-interrupt controller.
package irq_ctl_pkg;

  localparam int IRQ_ID_NONE = 0;

  function automatic int id_width(input int n);
    return $clog2(n + 1);
  endfunction

  // Source index i is reported to software as ID i+1; ID 0 is reserved for "none".
  function automatic int to_id(input int index);
    return index + 1;
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: reports the lowest set bit of vec_i.
module irq_prio_enc #(
  parameter int N  = 8,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  vec_i,
  output logic          valid_o,
  output logic [IW-1:0] idx_o
);

  always_comb begin
    valid_o = |vec_i;
    idx_o   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec_i[i]) idx_o = IW'(i);
    end
  end

endmodule

// File: rtl/irq_ctl.sv
// External-interrupt controller: synchronizes sources, tracks pending/in-service,
// drives the core exti line and runs the claim/complete handshake with nesting.
module irq_ctl
  import irq_ctl_pkg::*;
#(
  parameter int               N_IRQ       = 8,
  parameter int               SYNC_STAGES = 2,
  parameter logic [N_IRQ-1:0] EDGE_MASK   = '0,
  parameter int               ID_W        = id_width(N_IRQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IRQ-1:0] irq,
  input  logic             en_write,
  input  logic [N_IRQ-1:0] en_wdata,
  output logic [N_IRQ-1:0] en_reg,
  output logic [N_IRQ-1:0] pending,
  output logic [N_IRQ-1:0] in_service,
  output logic             exti,
  input  logic             claim,
  output logic [ID_W-1:0]  claim_id,
  input  logic             complete,
  input  logic [ID_W-1:0]  complete_id
);

  localparam int IDX_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

  logic [N_IRQ-1:0] sync_q [SYNC_STAGES];
  logic [N_IRQ-1:0] s, hist_q, rise_q;
  logic [N_IRQ-1:0] pend_q, pend_d, isv_q, isv_d, en_q, elig;
  logic [ID_W-1:0]  claim_id_q, claim_id_d;
  logic             best_v, top_v, fire;
  logic [IDX_W-1:0] best_idx, top_idx;

  for (genvar g = 0; g < SYNC_STAGES; g++) begin : g_sync
    if (g == 0) begin : g_first
      always_ff @(posedge clk) begin
        if (rst) sync_q[g] <= '0;
        else     sync_q[g] <= irq;
      end
    end else begin : g_next
      always_ff @(posedge clk) begin
        if (rst) sync_q[g] <= '0;
        else     sync_q[g] <= sync_q[g-1];
      end
    end
  end

  assign s    = sync_q[SYNC_STAGES-1];
  assign elig = pend_q & en_q & ~isv_q;

  irq_prio_enc #(.N(N_IRQ), .IW(IDX_W)) u_best (
    .vec_i(elig), .valid_o(best_v), .idx_o(best_idx)
  );
  irq_prio_enc #(.N(N_IRQ), .IW(IDX_W)) u_top (
    .vec_i(isv_q), .valid_o(top_v), .idx_o(top_idx)
  );

  // Only strictly higher priority than everything in service may interrupt again.
  assign exti = ~rst & best_v & (~top_v | (best_idx < top_idx));
  assign fire = claim & exti;

  always_comb begin
    pend_d     = pend_q;
    isv_d      = isv_q;
    claim_id_d = claim_id_q;
    if (claim) claim_id_d = fire ? ID_W'(to_id(int'(best_idx))) : ID_W'(IRQ_ID_NONE);
    for (int i = 0; i < N_IRQ; i++) begin
      // Edge sources use the registered rise so a new edge beats a same-cycle claim.
      if (EDGE_MASK[i]) pend_d[i] = rise_q[i] | (pend_q[i] & ~(fire && int'(best_idx) == i));
      else              pend_d[i] = s[i];
      if (fire && int'(best_idx) == i)             isv_d[i] = 1'b1;
      if (complete && int'(complete_id) == i + 1) isv_d[i] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q     <= '0;
      rise_q     <= '0;
      pend_q     <= '0;
      isv_q      <= '0;
      en_q       <= '0;
      claim_id_q <= '0;
    end else begin
      hist_q     <= s;
      rise_q     <= s & ~hist_q;
      pend_q     <= pend_d;
      isv_q      <= isv_d;
      claim_id_q <= claim_id_d;
      if (en_write) en_q <= en_wdata;
    end
  end

  assign en_reg     = en_q;
  assign pending    = pend_q;
  assign in_service = isv_q;
  assign claim_id   = claim_id_q;

endmodule

// File: tb/tb_irq_ctl.sv
// Bench for irq_ctl: directed vector table plus randomized traffic against a delay-line reference model.
module tb_irq_ctl;
  localparam int N = 8;
  localparam int SS = 2;
  localparam int IW = 4;
  localparam logic [N-1:0] EM = 8'h01;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] irq = '0, en_wdata = '0, en_reg, pending, in_service;
  logic en_write = 1'b0, claim = 1'b0, complete = 1'b0, exti;
  logic [IW-1:0] claim_id, complete_id = '0;

  always #5 clk = ~clk;

  irq_ctl #(.N_IRQ(N), .SYNC_STAGES(SS), .EDGE_MASK(EM)) dut (
    .clk(clk), .rst(rst), .irq(irq), .en_write(en_write), .en_wdata(en_wdata),
    .en_reg(en_reg), .pending(pending), .in_service(in_service), .exti(exti),
    .claim(claim), .claim_id(claim_id), .complete(complete), .complete_id(complete_id)
  );

  int errs = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: hq[k] is the irq value sampled k+1 edges before the upcoming edge.
  bit [N-1:0] m_pend, m_isv, m_en;
  int         m_cid;
  bit [N-1:0] hq [8];

  function automatic int m_best();
    for (int i = 0; i < N; i++) if (m_pend[i] && m_en[i] && !m_isv[i]) return i;
    return -1;
  endfunction

  function automatic int m_top();
    for (int i = 0; i < N; i++) if (m_isv[i]) return i;
    return -1;
  endfunction

  function automatic bit m_exti();
    int b, t;
    b = m_best();
    t = m_top();
    return !rst && b >= 0 && (t < 0 || b < t);
  endfunction

  task automatic model_edge();
    bit [N-1:0] np;
    int b;
    bit fire;
    if (rst) begin
      m_pend = '0; m_isv = '0; m_en = '0; m_cid = 0;
      for (int k = 0; k < 8; k++) hq[k] = '0;
      return;
    end
    b = m_best();
    fire = claim && m_exti();
    for (int i = 0; i < N; i++) begin
      if (EM[i]) np[i] = (hq[SS][i] && !hq[SS+1][i]) || (m_pend[i] && !(fire && b == i));
      else       np[i] = hq[SS-1][i];
    end
    if (claim) m_cid = fire ? b + 1 : 0;
    if (fire) m_isv[b] = 1'b1;
    if (complete && complete_id >= 1 && complete_id <= N) m_isv[complete_id-1] = 1'b0;
    if (en_write) m_en = en_wdata;
    m_pend = np;
    for (int k = 7; k > 0; k--) hq[k] = hq[k-1];
    hq[0] = irq;
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    @(negedge clk);
    chk({tag, ".exti"},       exti,       m_exti());
    chk({tag, ".claim_id"},   claim_id,   m_cid);
    chk({tag, ".pending"},    pending,    m_pend);
    chk({tag, ".in_service"}, in_service, m_isv);
    chk({tag, ".en_reg"},     en_reg,     m_en);
  endtask

  typedef struct {
    bit rst; bit [N-1:0] irq; bit enw; bit [N-1:0] enwd;
    bit clm; bit cmp; bit [IW-1:0] cid;
    bit x_exti; bit [IW-1:0] x_cid; bit [N-1:0] x_pend; bit [N-1:0] x_isv;
  } vec_t;
  vec_t tbl[$];

  task automatic v(input bit r, input bit [N-1:0] i, input bit w, input bit [N-1:0] wd,
                   input bit c, input bit cp, input bit [IW-1:0] ci,
                   input bit xe, input bit [IW-1:0] xc, input bit [N-1:0] xp, input bit [N-1:0] xi);
    vec_t t;
    t.rst = r; t.irq = i; t.enw = w; t.enwd = wd; t.clm = c; t.cmp = cp; t.cid = ci;
    t.x_exti = xe; t.x_cid = xc; t.x_pend = xp; t.x_isv = xi;
    tbl.push_back(t);
  endtask

  initial begin
    // reset then idle with sources up and everything disabled
    v(1,8'hFF,0,0,0,0,0, 0,0,8'h00,8'h00);
    v(1,8'hFF,0,0,0,0,0, 0,0,8'h00,8'h00);
    v(0,8'hFF,0,0,0,0,0, 0,0,8'h00,8'h00);
    v(0,8'hFF,0,0,0,0,0, 0,0,8'h00,8'h00);
    v(0,8'hFF,0,0,0,0,0, 0,0,8'hFE,8'h00);
    v(0,8'hFF,0,0,0,0,0, 0,0,8'hFF,8'h00);
    v(0,8'h00,0,0,1,0,0, 0,0,8'hFF,8'h00);  // claim with nothing eligible
    v(0,8'h00,0,0,0,0,0, 0,0,8'hFF,8'h00);
    v(0,8'h00,0,0,0,0,0, 0,0,8'h01,8'h00);
    v(1,8'h00,0,0,0,0,0, 0,0,8'h00,8'h00);
    // edge latency, claim, complete
    v(0,8'h01,1,8'hFF,0,0,0, 0,0,8'h00,8'h00);
    v(0,8'h00,0,0,0,0,0, 0,0,8'h00,8'h00);
    v(0,8'h00,0,0,0,0,0, 0,0,8'h00,8'h00);
    v(0,8'h00,0,0,0,0,0, 1,0,8'h01,8'h00);
    v(0,8'h00,0,0,1,0,0, 0,1,8'h00,8'h01);
    v(0,8'h00,0,0,0,1,1, 0,1,8'h00,8'h00);
    // priority and preemption
    v(0,8'h24,0,0,0,0,0, 0,1,8'h00,8'h00);
    v(0,8'h24,0,0,0,0,0, 0,1,8'h00,8'h00);
    v(0,8'h24,0,0,0,0,0, 1,1,8'h24,8'h00);
    v(0,8'h24,0,0,1,0,0, 0,3,8'h24,8'h04);
    v(0,8'h25,0,0,0,0,0, 0,3,8'h24,8'h04);
    v(0,8'h25,0,0,0,0,0, 0,3,8'h24,8'h04);
    v(0,8'h25,0,0,0,0,0, 0,3,8'h24,8'h04);
    v(0,8'h25,0,0,0,0,0, 1,3,8'h25,8'h04);
    v(0,8'h25,0,0,1,0,0, 0,1,8'h24,8'h05);
    v(1,8'h00,0,0,0,0,0, 0,0,8'h00,8'h00);  // reset during nested service
    // level hold across complete
    v(0,8'h08,1,8'hFF,0,0,0, 0,0,8'h00,8'h00);
    v(0,8'h08,0,0,0,0,0, 0,0,8'h00,8'h00);
    v(0,8'h08,0,0,0,0,0, 1,0,8'h08,8'h00);
    v(0,8'h08,0,0,1,0,0, 0,4,8'h08,8'h08);
    v(0,8'h08,0,0,0,1,4, 1,4,8'h08,8'h00);
    v(0,8'h00,0,0,0,0,0, 1,4,8'h08,8'h00);
    v(0,8'h00,0,0,0,0,0, 1,4,8'h08,8'h00);
    v(0,8'h00,0,0,0,0,0, 0,4,8'h00,8'h00);
    // new edge during claim; claim+complete of the same ID
    v(0,8'h01,0,0,0,0,0, 0,4,8'h00,8'h00);
    v(0,8'h00,0,0,0,0,0, 0,4,8'h00,8'h00);
    v(0,8'h01,0,0,0,0,0, 0,4,8'h00,8'h00);
    v(0,8'h00,0,0,0,0,0, 1,4,8'h01,8'h00);
    v(0,8'h00,0,0,0,0,0, 1,4,8'h01,8'h00);
    v(0,8'h00,0,0,1,0,0, 0,1,8'h01,8'h01);
    v(0,8'h00,0,0,0,1,1, 1,1,8'h01,8'h00);
    v(0,8'h00,0,0,1,1,1, 0,1,8'h00,8'h00);
    // ignored completes
    v(0,8'h02,0,0,0,0,0, 0,1,8'h00,8'h00);
    v(0,8'h02,0,0,0,0,0, 0,1,8'h00,8'h00);
    v(0,8'h02,0,0,0,0,0, 1,1,8'h02,8'h00);
    v(0,8'h02,0,0,1,0,0, 0,2,8'h02,8'h02);
    v(0,8'h02,0,0,0,1,0, 0,2,8'h02,8'h02);
    v(0,8'h02,0,0,0,1,9, 0,2,8'h02,8'h02);
    v(0,8'h02,0,0,0,1,3, 0,2,8'h02,8'h02);
    v(0,8'h02,0,0,0,1,2, 1,2,8'h02,8'h00);

    foreach (tbl[n]) begin
      rst = tbl[n].rst; irq = tbl[n].irq; en_write = tbl[n].enw; en_wdata = tbl[n].enwd;
      claim = tbl[n].clm; complete = tbl[n].cmp; complete_id = tbl[n].cid;
      step($sformatf("model%0d", n));
      chk($sformatf("vec%0d.exti", n),       exti,       tbl[n].x_exti);
      chk($sformatf("vec%0d.claim_id", n),   claim_id,   tbl[n].x_cid);
      chk($sformatf("vec%0d.pending", n),    pending,    tbl[n].x_pend);
      chk($sformatf("vec%0d.in_service", n), in_service, tbl[n].x_isv);
    end

    for (int n = 0; n < 2000; n++) begin
      rst         = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 3) == 0) irq = irq ^ (N'($urandom) & N'($urandom));
      en_write    = ($urandom_range(0, 15) == 0);
      en_wdata    = N'($urandom);
      claim       = ($urandom_range(0, 2) == 0);
      complete    = ($urandom_range(0, 2) == 0);
      complete_id = IW'($urandom_range(0, 10));
      step($sformatf("rnd%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
